// File: rtl/adder_arb_pkg.sv
// Shared constants and the round-robin pick helper for the adder arbiter.
package adder_arb_pkg;

    localparam int ADD_W    = 64;
    localparam int NREQ_MAX = 8;
    localparam int IDX_W    = $clog2(NREQ_MAX);

    // Result of a round-robin search: grant index and whether anything was valid.
    typedef struct packed {
        logic             any;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First valid requester at or after ptr, wrapping modulo nreq.
    // Bits of valid at or above nreq are ignored.
    function automatic rr_pick_t rr_pick(input logic [NREQ_MAX-1:0] valid,
                                         input logic [IDX_W-1:0]    ptr,
                                         input int                  nreq);
        rr_pick_t res;
        int       j;
        res.any = 1'b0;
        res.idx = '0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            if (k < nreq) begin
                j = int'(ptr) + k;
                if (j >= nreq) j = j - nreq;
                if (!res.any && valid[j]) begin
                    res.any = 1'b1;
                    res.idx = IDX_W'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/Con_sa_16_bit_block_64.sv
// 64-bit carry-select adder built from 16-bit blocks. The lowest block
// ripples from the real carry-in; each upper block precomputes both
// carry-in cases and the incoming block carry picks one.
module Con_sa_16_bit_block_64
    import adder_arb_pkg::*;
(
    input  logic [ADD_W-1:0] i_a,
    input  logic [ADD_W-1:0] i_b,
    input  logic             i_cin,
    output logic [ADD_W-1:0] o_sum,
    output logic             o_cout
);

    localparam int BLK  = 16;
    localparam int NBLK = ADD_W / BLK;

    logic [NBLK:0] w_c;

    assign w_c[0] = i_cin;

    genvar b;
    generate
        for (b = 0; b < NBLK; b++) begin : g_blk
            if (b == 0) begin : g_first
                logic [BLK:0] w_s;
                assign w_s = {1'b0, i_a[BLK-1:0]} + {1'b0, i_b[BLK-1:0]}
                           + {{BLK{1'b0}}, w_c[0]};
                assign o_sum[BLK-1:0] = w_s[BLK-1:0];
                assign w_c[1]         = w_s[BLK];
            end else begin : g_sel
                logic [BLK:0] w_s0;
                logic [BLK:0] w_s1;
                assign w_s0 = {1'b0, i_a[b*BLK +: BLK]} + {1'b0, i_b[b*BLK +: BLK]};
                assign w_s1 = w_s0 + {{BLK{1'b0}}, 1'b1};
                assign o_sum[b*BLK +: BLK] = w_c[b] ? w_s1[BLK-1:0] : w_s0[BLK-1:0];
                assign w_c[b+1]            = w_c[b] ? w_s1[BLK]     : w_s0[BLK];
            end
        end
    endgenerate

    assign o_cout = w_c[NBLK];

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin front end for the shared 64-bit adder. One requester is
// granted per cycle; its result is registered together with its ID.
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ADD_W-1:0] req_a,
    input  logic [NREQ*ADD_W-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ADD_W-1:0]      res_sum,
    output logic                  res_cout,
    output logic [IDW-1:0]        res_id,
    output logic [15:0]           busy_cnt
);

    logic [NREQ-1:0][ADD_W-1:0] w_a_arr;
    logic [NREQ-1:0][ADD_W-1:0] w_b_arr;
    logic                       w_can_accept;
    rr_pick_t                   w_pick;
    logic [IDW-1:0]             w_g;
    logic                       w_xfer;
    logic [ADD_W-1:0]           w_sum;
    logic                       w_cout;
    logic [IDW-1:0]             w_ptr_nxt;

    logic                       r_res_valid;
    logic [ADD_W-1:0]           r_res_sum;
    logic                       r_res_cout;
    logic [IDW-1:0]             r_res_id;
    logic [IDW-1:0]             r_ptr;
    logic [15:0]                r_busy_cnt;

    // Flat operand buses viewed as one lane per requester.
    assign w_a_arr = req_a;
    assign w_b_arr = req_b;

    // The result slot is free if empty or being drained this cycle.
    assign w_can_accept = !r_res_valid | res_ready;

    assign w_pick = rr_pick(NREQ_MAX'(req_valid), IDX_W'(r_ptr), NREQ);
    assign w_g    = w_pick.idx[IDW-1:0];
    assign w_xfer = w_can_accept & w_pick.any;

    assign w_ptr_nxt = (w_g == IDW'(NREQ - 1)) ? '0 : w_g + 1'b1;

    // One-hot grant toward the picked requester only when the slot is free.
    always_comb begin
        req_ready = '0;
        if (w_xfer) req_ready[w_g] = 1'b1;
    end

    Con_sa_16_bit_block_64 u_add (
        .i_a    (w_a_arr[w_g]),
        .i_b    (w_b_arr[w_g]),
        .i_cin  (req_cin[w_g]),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Result register: load on transfer, clear valid on a plain drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_cout  <= 1'b0;
            r_res_id    <= '0;
        end else if (w_xfer) begin
            r_res_valid <= 1'b1;
            r_res_sum   <= w_sum;
            r_res_cout  <= w_cout;
            r_res_id    <= w_g;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    // Round-robin pointer moves just past the requester that was served.
    always_ff @(posedge clk) begin
        if (rst)         r_ptr <= '0;
        else if (w_xfer) r_ptr <= w_ptr_nxt;
    end

    // Saturating count of cycles where work waited on a blocked result slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_cnt <= '0;
        end else if ((|req_valid) && !w_can_accept && (r_busy_cnt != 16'hFFFF)) begin
            r_busy_cnt <= r_busy_cnt + 16'd1;
        end
    end

    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;
    assign res_id    = r_res_id;
    assign busy_cnt  = r_busy_cnt;

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one 64-bit carry-select adder datapath (Con_sa_16_bit_block_64) between NREQ independent requesters.
- Each requester offers an operand pair and carry-in with a valid/ready handshake. The block grants one requester per cycle, round-robin, and registers the result with the requester's ID.
- Sits between the issue logic of several client units and the shared adder. It is the only path into the adder.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), width of the requester ID (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant/accept, combinational
- req_a  in  NREQ*64  operand A, requester i in bits [64*i+63:64*i]
- req_b  in  NREQ*64  operand B, same packing
- req_cin  in  NREQ  carry-in per requester
- res_valid  out  1  result register holds a valid result
- res_ready  in  1  downstream accepts the result
- res_sum  out  64  registered sum
- res_cout  out  1  registered carry-out
- res_id  out  IDW  index of the requester that produced the result
- busy_cnt  out  16  saturating count of cycles where a request was pending but none was accepted

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values, on the first clk edge with rst=1:
  - res_valid=0, res_sum=0, res_cout=0, res_id=0
  - busy_cnt=0
  - round-robin pointer ptr=0
- Arithmetic: {res_cout,res_sum} = req_a[g] + req_b[g] + req_cin[g], 65-bit exact. Wraps mod 2^64 with the carry in res_cout.
- Acceptance condition: can_accept = !res_valid | res_ready.
- Grant selection: g is the first i with req_valid[i]=1, searching from ptr upward modulo NREQ.
- req_ready[g]=1 only when can_accept=1 and some req_valid is high. At most one req_ready bit is high in any cycle. req_ready never depends on res_valid of the same cycle except through can_accept.
- Transfer on requester g happens when req_valid[g] & req_ready[g]. On that edge:
  - result register loads sum, cout and g
  - res_valid=1
  - ptr = (g+1) mod NREQ
- Latency: 1 cycle from transfer to res_valid. Throughput is 1 op/cycle when res_ready stays high.
- Drain without new transfer: res_valid & res_ready and no transfer -> res_valid=0. Data fields hold their last value.
- Backpressure: res_valid & !res_ready -> no grant, output fields stable, ptr unchanged.
- Requester-side rule: a requester must hold req_valid and its operands stable until accepted. The arbiter does not latch operands before acceptance.
- Starvation bound: a continuously valid requester is accepted within NREQ accepted transfers.
- busy_cnt increments when |req_valid & !can_accept. It saturates at 16'hFFFF and clears only on rst.
- Simultaneous drain and accept: allowed in the same cycle, which gives the full-rate path.
- No valid requests: ptr holds and nothing changes.
- Reset mid-operation: a pending result is discarded (res_valid=0). The in-flight request is not acknowledged and its requester must re-present it.

Decomposition:
- Shared package adder_arb_pkg holds:
  - constant ADD_W=64
  - constant NREQ_MAX=8
  - function rr_pick(valid, ptr), returning the grant index and an any-valid flag
- Datapath sub-module: Con_sa_16_bit_block_64, instantiated once. Its inputs come from a NREQ:1 operand mux driven by g.
- The round-robin picker stays in this module as the package function; no separate module for it.

Test Plan:
- Single op: rst for 2 cycles, then req0 a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, res_ready=1 -> next cycle res_valid=1, res_sum=0, res_cout=1, res_id=0.
- Carry-in propagation: req2 a=64'h0000_0000_FFFF_FFFF, b=0, cin=1 -> res_sum=64'h0000_0001_0000_0000, res_cout=0, res_id=2.
- Fairness: all 4 requesters held valid for 8 cycles with res_ready=1 -> res_id sequence 0,1,2,3,0,1,2,3; exactly one req_ready high per cycle.
- Backpressure: result pending, res_ready=0 for 3 cycles with req1 valid -> req_ready=0, outputs stable, busy_cnt=3. Then res_ready=1 -> req1 accepted that cycle and its result appears on the next edge.
- Pointer skip: ptr=1, only req3 and req0 valid -> req3 granted first, then req0.
- Reset mid-op: assert rst while res_valid=1 and res_ready=0 -> next cycle res_valid=0, busy_cnt=0, and the next grant goes to req0.
